fp32_divide_iter: RTL and testbench

- Iterative IEEE-754 single-precision divider: Quotient = Number_1 / Number_2.
- Counterpart to the FP32 multiplier stage in the fast inverse square root datapath.
- Used for the reciprocal/normalisation direction; also the reference model for checking the multiply-based path.
- Radix-2 restoring mantissa division, fixed latency, start/busy/valid handshake, truncation rounding to match the multiplier.

---
 rtl/fp32_divide_iter.sv | 162 ++++++++++++++++
 tb/tb_fp32_divide_iter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fp32_divide_iter.sv
// Iterative FP32 divider: Quotient = Number_1 / Number_2.
// Radix-2 restoring mantissa division, one quotient bit per enabled cycle.
// Results are truncated. Special cases: zero/denormal operands, exponent
// overflow (saturates to infinity) and underflow (flushes to zero).
module fp32_divide_iter #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int BIAS   = 127
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ce,
   input  logic                      Start,
   input  logic [EXP_W+FRAC_W:0]     Number_1,
   input  logic [EXP_W+FRAC_W:0]     Number_2,
   output logic [EXP_W+FRAC_W:0]     Quotient,
   output logic                      Valid,
   output logic                      Busy,
   output logic                      Div_zero,
   output logic                      Overflow
);

   localparam int W  = EXP_W + FRAC_W + 1;   // word width
   localparam int MW = FRAC_W + 1;           // mantissa with hidden bit
   localparam int QW = FRAC_W + 2;           // quotient bits = iterations
   localparam int RW = FRAC_W + 3;           // partial remainder width
   localparam int EW = EXP_W + 2;            // signed exponent width
   localparam int CW = $clog2(QW);

   localparam logic signed [EW-1:0] EXP_INF  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic [RW-1:0]   r_q, r_d;
   logic [QW-1:0]   q_q, q_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    quot_q, quot_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            dz_q, dz_d;
   logic            ov_q, ov_d;

   logic [RW-1:0]          m2_ext;
   logic                   ge;
   logic                   sign;
   logic [EXP_W-1:0]       e1, e2;
   logic signed [EW-1:0]   exp_raw, exp_fin;
   logic [FRAC_W-1:0]      frac;

   // Datapath terms shared by the iteration and the packing step.
   assign m2_ext  = {{(RW-MW){1'b0}}, 1'b1, b_q[FRAC_W-1:0]};
   assign ge      = (r_q >= m2_ext);
   assign sign    = a_q[W-1] ^ b_q[W-1];
   assign e1      = a_q[W-2:FRAC_W];
   assign e2      = b_q[W-2:FRAC_W];
   assign exp_raw = $signed({2'b00, e1}) - $signed({2'b00, e2}) + $signed(EW'(BIAS));
   // A quotient below 1.0 needs one left shift, costing one exponent step.
   assign exp_fin = q_q[QW-1] ? exp_raw : exp_raw - EW'(1);
   assign frac    = q_q[QW-1] ? q_q[QW-2:1] : q_q[QW-3:0];

   // Next-state and datapath updates for the IDLE/DIV/NORM/DONE sequence.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      dz_d    = dz_q;
      ov_d    = ov_q;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (Start) begin
               a_d     = Number_1;
               b_d     = Number_2;
               r_d     = {{(RW-MW){1'b0}}, 1'b1, Number_1[FRAC_W-1:0]};
               q_d     = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            q_d   = {q_q[QW-2:0], ge};
            r_d   = (ge ? (r_q - m2_ext) : r_q) << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(QW-1)) begin
               cnt_d   = '0;
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            dz_d = 1'b0;
            ov_d = 1'b0;
            if (e2 == '0) begin
               quot_d = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
               dz_d   = 1'b1;
            end else if (e1 == '0) begin
               quot_d = {sign, {(W-1){1'b0}}};
            end else if (exp_fin >= EXP_INF) begin
               quot_d = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
               ov_d   = 1'b1;
            end else if (exp_fin <= EXP_ZERO) begin
               quot_d = {sign, {(W-1){1'b0}}};
            end else begin
               quot_d = {sign, exp_fin[EXP_W-1:0], frac};
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            // Valid is registered, so it appears in the cycle after DONE
            // while Busy is still held; a new Start is taken in that cycle.
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register: reset wins over ce, ce low freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else if (ce) begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
      end
   end

   assign Quotient = quot_q;
   assign Valid    = valid_q;
   assign Busy     = busy_q;
   assign Div_zero = dz_q;
   assign Overflow = ov_q;

endmodule

// File: tb/tb_fp32_divide_iter.sv
// Directed bench for fp32_divide_iter: vector table plus hand sequences
// for clock-enable stalls, ignored Start, reset abort and back-to-back issue.
module tb_fp32_divide_iter;

   logic        clk = 1'b0;
   logic        rst, ce, Start;
   logic [31:0] Number_1, Number_2;
   logic [31:0] Quotient;
   logic        Valid, Busy, Div_zero, Overflow;

   int errors = 0;
   int checks = 0;

   fp32_divide_iter dut (
      .clk(clk), .rst(rst), .ce(ce), .Start(Start),
      .Number_1(Number_1), .Number_2(Number_2),
      .Quotient(Quotient), .Valid(Valid), .Busy(Busy),
      .Div_zero(Div_zero), .Overflow(Overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic        dz;
      logic        ov;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Issue one operation and wait for Valid. Optional ce stall and a
   // stray Start pulse while busy. Returns at the negedge of the Valid cycle.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        input int gap_at, input int gap_len, input bit poke,
                        output logic [31:0] q, output logic dz, output logic ov,
                        output int lat);
      bit seen;
      Number_1 = a; Number_2 = b; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0; Number_1 = 32'h0; Number_2 = 32'h0;
      lat = 0; seen = 1'b0;
      q = 32'h0; dz = 1'b0; ov = 1'b0;
      while (lat < 200 && !seen) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (lat == 1) chk("busy_after_start", {31'h0, Busy}, 32'h1);
         if (gap_at > 0 && lat == gap_at) ce = 1'b0;
         if (gap_at > 0 && lat == gap_at + gap_len) ce = 1'b1;
         if (poke && lat == 5) begin
            Start = 1'b1; Number_1 = 32'h3F800000; Number_2 = 32'h40400000;
         end
         if (poke && lat == 6) Start = 1'b0;
         if (Valid) seen = 1'b1;
      end
      if (!seen) begin
         errors++; checks++;
         $display("FAIL valid_timeout: got no Valid after %0d cycles expected Valid", lat);
      end
      q = Quotient; dz = Div_zero; ov = Overflow;
   endtask

   vec_t vecs[9];

   initial begin
      logic [31:0] q;
      logic        dz, ov;
      int          lat, nv;

      vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0}; // 6/2
      vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0}; // 1/3
      vecs[2] = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 1'b0, 1'b0}; // 1/1.5
      vecs[3] = '{32'hC1000000, 32'h40000000, 32'hC0800000, 1'b0, 1'b0}; // -8/2
      vecs[4] = '{32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 1'b0}; // 0/5
      vecs[5] = '{32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1'b0}; // -0/5
      vecs[6] = '{32'h00800000, 32'h4B000000, 32'h00000000, 1'b0, 1'b0}; // underflow
      vecs[7] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0}; // 1/0
      vecs[8] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b1}; // overflow

      rst = 1'b1; ce = 1'b1; Start = 1'b0; Number_1 = '0; Number_2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_quotient", Quotient, 32'h0);
      chk("reset_flags", {27'h0, Valid, Busy, Div_zero, Overflow}, 32'h0);
      rst = 1'b0;

      // Table vectors, issued back-to-back (Start held in the Valid cycle).
      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].a, vecs[i].b, 0, 0, 1'b0, q, dz, ov, lat);
         chk($sformatf("vec%0d_quotient", i), q, vecs[i].q);
         chk($sformatf("vec%0d_div_zero", i), {31'h0, dz}, {31'h0, vecs[i].dz});
         chk($sformatf("vec%0d_overflow", i), {31'h0, ov}, {31'h0, vecs[i].ov});
         chk($sformatf("vec%0d_latency", i), lat, 27);
      end

      // ce low for 5 cycles mid-DIV plus a Start pulse while busy.
      do_op(32'h40C00000, 32'h40000000, 10, 5, 1'b1, q, dz, ov, lat);
      chk("stall_quotient", q, 32'h40400000);
      chk("stall_flags", {30'h0, dz, ov}, 32'h0);
      chk("stall_latency", lat, 32);
      nv = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (Valid) nv++;
      end
      chk("single_valid", nv, 1);
      chk("busy_idle", {31'h0, Busy}, 32'h0);

      // Leave a nonzero result and flag so the reset clear is visible.
      do_op(vecs[8].a, vecs[8].b, 0, 0, 1'b0, q, dz, ov, lat);
      chk("pre_reset_quotient", q, 32'h7F800000);
      @(negedge clk);

      // Reset during DIV aborts the operation.
      Number_1 = 32'h40C00000; Number_2 = 32'h40000000; Start = 1'b1;
      @(posedge clk); #1; Start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("abort_quotient", Quotient, 32'h0);
      chk("abort_flags", {27'h0, Valid, Busy, Div_zero, Overflow}, 32'h0);
      rst = 1'b0;
      nv = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (Valid) nv++;
      end
      chk("abort_no_valid", nv, 0);

      do_op(32'h3F800000, 32'h40400000, 0, 0, 1'b0, q, dz, ov, lat);
      chk("after_abort_quotient", q, 32'h3EAAAAAA);
      chk("after_abort_latency", lat, 27);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
